serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parallel-to-serial frame transmitter: accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit at a time on a single serial line. A selectable bit order matches the left/right-shifting serial receiver. A programmable clock divider sets the bit period, and a per-bit strobe marks when the receiver shifts. It sits upstream of the team's bidirectional shift register and generates its SI stream.

## Interface
- WIDTH, 8: bits per frame; must be ≥2.
- DIV, 4: clock cycles per bit; must be ≥1.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- din  input  WIDTH  parallel word; sampled only on accept.
- LR  input  1  bit order, sampled on accept: 0 = MSB first (feeds a left-shifting receiver); 1 = LSB first (feeds a right-shifting receiver).
- valid  input  1  din/LR are presented.
- ready  output  1  transmitter idle and able to accept.
- SO  output  1  serial data out.
- SO_en  output  1  high while SO carries a frame bit.
- bit_stb  output  1  one-cycle pulse in the last cycle of each bit period.
- done  output  1  one-cycle pulse after the final bit.

## Operation
- States:
  - IDLE: ready=1, SO=0, SO_en=0.
  - SHIFT: frame bits on SO.
  - DONE: single cycle, done=1, ready=0.
- Accept occurs on a clock edge with valid && ready && !rst.
- On accept:
  - Latch din into the shift register and LR into the direction flag.
  - Clear the divider counter (0..DIV-1) and the bit counter (0..WIDTH-1).
  - Go to SHIFT.
- In SHIFT:
  - SO = shreg[WIDTH-1] when the latched LR=0; SO = shreg[0] when LR=1.
  - SO_en=1.
- Divider:
  - Increments every SHIFT cycle.
  - When it equals DIV-1: bit_stb=1; on that edge the divider wraps to 0 and the bit counter increments.
  - On the same edge shreg shifts toward the output end, left for LR=0 and right for LR=1, with 0 filled in.
- When bit_stb is high and bit counter = WIDTH-1: go to DONE. Next state after DONE is IDLE.
- din and LR changes after accept have no effect on the frame in flight.
- valid while not ready: ignored. The word is accepted once ready returns, provided valid is still high.
- rst at any time, including mid-frame:
  - Next state IDLE, counters 0, shreg 0.
  - Frame aborted; no done pulse.
- Reset values, first cycle after the rst edge: ready=1, SO=0, SO_en=0, bit_stb=0, done=0.
- While rst is high: ready=0.

## Timing
- Accept at edge E0. SO shows bit 0 of the frame in cycle 1 after E0.
- Bit k (0-based) is held on SO for cycles k*DIV+1 through (k+1)*DIV after E0.
- bit_stb is high in cycle (k+1)*DIV.
- done is high in cycle WIDTH*DIV+1. ready is high again in cycle WIDTH*DIV+2.
- Back-to-back throughput with valid held high: one frame every WIDTH*DIV+2 cycles.
- DIV=1: bit_stb is high in every SHIFT cycle; SO changes every cycle.
- All outputs are decoded from registered state only; no combinational path from valid/din to SO.

## Test plan
- Reset: assert rst 2 cycles with valid=1 -> ready=0, SO/SO_en/bit_stb/done=0 during rst, no accept. First cycle after rst: ready=1.
- MSB-first, WIDTH=8, DIV=4, din=0xB1, LR=0:
  - SO sequence 1,0,1,1,0,0,0,1, each bit held 4 cycles.
  - 8 bit_stb pulses at cycles 4,8,…,32.
  - done at cycle 33; ready at cycle 34.
- LSB-first, same din=0xB1 with LR=1 -> SO sequence 1,0,0,0,1,1,0,1.
- Loopback, DIV=1:
  - Setup: SO drives the shift register's SI on the same clk, with the same LR value.
  - Required: during the done cycle the receiver register equals din, for din=0xB1 and 0x5E in both LR settings.
- Back-to-back: valid held high with 0x0F then 0xF0, DIV=2 -> second accept exactly 18 cycles after the first; no gap bits on SO_en beyond the 2-cycle DONE/IDLE gap.
- Mid-frame reset: rst pulsed after bit 3 of 0xFF -> SO=0, SO_en=0 next cycle, no done pulse, ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx.
// master = word producer, slave = the transmitter.
interface serial_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             LR;
  logic             valid;
  logic             ready;
  logic             SO;
  logic             SO_en;
  logic             bit_stb;
  logic             done;

  modport master (
    output din, LR, valid,
    input  ready, SO, SO_en, bit_stb, done
  );

  modport slave (
    input  din, LR, valid,
    output ready, SO, SO_en, bit_stb, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter with selectable bit order and a clock divider
// setting the bit period; bit_stb marks the last cycle of each bit.
module serial_frame_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input logic              clk,
  input logic              rst,
  serial_frame_tx_if.slave bus
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           st_q, st_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             lr_q, lr_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [CntW-1:0]  bit_q, bit_d;
  logic             stb;

  always_comb begin
    st_d    = st_q;
    shreg_d = shreg_q;
    lr_d    = lr_q;
    div_d   = div_q;
    bit_d   = bit_q;
    stb     = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (bus.valid) begin
          shreg_d = bus.din;
          lr_d    = bus.LR;
          div_d   = '0;
          bit_d   = '0;
          st_d    = StShift;
        end
      end
      StShift: begin
        stb = (div_q == DivLast);
        if (stb) begin
          div_d   = '0;
          bit_d   = bit_q + 1'b1;
          // Move the next frame bit toward whichever end drives SO.
          shreg_d = lr_q ? (shreg_q >> 1) : (shreg_q << 1);
          if (bit_q == BitLast) begin
            st_d = StDone;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        st_d = StIdle;
      end
      default: begin
        st_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      shreg_q <= '0;
      lr_q    <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      st_q    <= st_d;
      shreg_q <= shreg_d;
      lr_q    <= lr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
    end
  end

  // ready is the only output that looks at rst, so nothing is accepted while it is held.
  assign bus.ready   = (st_q == StIdle) && !rst;
  assign bus.SO_en   = (st_q == StShift);
  assign bus.SO      = (st_q == StShift) ? (lr_q ? shreg_q[0] : shreg_q[WIDTH-1]) : 1'b0;
  assign bus.bit_stb = stb;
  assign bus.done    = (st_q == StDone);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: random frames scored against a per-bit reference model,
// plus loopback, back-to-back and mid-frame reset scenarios on differently divided copies.
module tb_serial_frame_tx;

  localparam int unsigned W    = 8;
  localparam int unsigned DIVA = 4;
  localparam int unsigned DIVB = 1;
  localparam int unsigned DIVC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_tx_if #(.WIDTH(W)) a_if ();
  serial_frame_tx_if #(.WIDTH(W)) b_if ();
  serial_frame_tx_if #(.WIDTH(W)) c_if ();

  serial_frame_tx #(.WIDTH(W), .DIV(DIVA)) u_a (.clk(clk), .rst(rst_a), .bus(a_if));
  serial_frame_tx #(.WIDTH(W), .DIV(DIVB)) u_b (.clk(clk), .rst(rst_b), .bus(b_if));
  serial_frame_tx #(.WIDTH(W), .DIV(DIVC)) u_c (.clk(clk), .rst(rst_c), .bus(c_if));

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [W-1:0] d;
    logic         lr;
    int unsigned  acc;
  } frame_t;

  frame_t exp_q[$];

  // Scoreboard monitor for u_a: every frame cycle is checked against the bit the word implies.
  initial begin : mon_a
    frame_t f;
    logic   exp_bit;
    forever begin
      @(negedge clk);
      if (!rst_a && a_if.done) chk("a_stray_done", 32'(a_if.done), 32'd0);
      if (!rst_a && a_if.SO_en) begin
        if (exp_q.size() == 0) begin
          chk("a_unexpected_frame", 32'(a_if.SO_en), 32'd0);
        end else begin
          f = exp_q.pop_front();
          chk("a_start_cycle", cyc, f.acc + 1);
          for (int k = 0; k < W; k++) begin
            for (int c = 0; c < DIVA; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              exp_bit = f.lr ? f.d[k] : f.d[W-1-k];
              chk("a_en_so_stb", 32'({a_if.SO_en, a_if.SO, a_if.bit_stb}),
                  32'({1'b1, exp_bit, (c == DIVA - 1)}));
            end
          end
          @(negedge clk);
          chk("a_done_cycle", 32'({a_if.done, a_if.SO_en, a_if.ready}), 32'b100);
          @(negedge clk);
          chk("a_ready_cycle", 32'({a_if.done, a_if.ready}), 32'b01);
        end
      end
    end
  end

  task automatic send_a(input logic [W-1:0] d, input logic lr);
    int     n = 0;
    frame_t f;
    a_if.din   = d;
    a_if.LR    = lr;
    a_if.valid = 1'b1;
    while (!a_if.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_if.ready) begin
      chk("a_accept_timeout", 32'(a_if.ready), 32'd1);
      a_if.valid = 1'b0;
      return;
    end
    f.d   = d;
    f.lr  = lr;
    f.acc = cyc;
    exp_q.push_back(f);
    @(negedge clk);
    a_if.valid = 1'b0;
    a_if.din   = W'($urandom);
    a_if.LR    = 1'($urandom);
  endtask

  task automatic run_a();
    rst_a      = 1'b1;
    a_if.valid = 1'b1;
    a_if.din   = 8'hB1;
    a_if.LR    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("a_during_rst", 32'({a_if.ready, a_if.SO, a_if.SO_en, a_if.bit_stb, a_if.done}),
          32'd0);
    end
    rst_a      = 1'b0;
    a_if.valid = 1'b0;
    @(negedge clk);
    chk("a_after_rst", 32'({a_if.ready, a_if.SO, a_if.SO_en, a_if.bit_stb, a_if.done}),
        32'b10000);
    send_a(8'hB1, 1'b0);
    send_a(8'hB1, 1'b1);
    repeat (20) send_a(W'($urandom), 1'($urandom));
    repeat (W * DIVA + 6) @(negedge clk);
    chk("a_queue_drained", exp_q.size(), 32'd0);
  endtask

  // Receiver for the loopback test: shifts SO in on each bit strobe.
  logic [W-1:0] rx;
  logic         rx_lr;
  always @(posedge clk) begin
    if (!rst_b && b_if.bit_stb) rx <= rx_lr ? {b_if.SO, rx[W-1:1]} : {rx[W-2:0], b_if.SO};
  end

  task automatic run_b();
    logic [W-1:0] words[2];
    int           n;
    words[0]   = 8'hB1;
    words[1]   = 8'h5E;
    rst_b      = 1'b1;
    b_if.valid = 1'b0;
    b_if.din   = '0;
    b_if.LR    = 1'b0;
    rx_lr      = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      for (int l = 0; l < 2; l++) begin
        rx_lr      = 1'(l);
        b_if.din   = words[i];
        b_if.LR    = 1'(l);
        b_if.valid = 1'b1;
        n = 0;
        while (!b_if.ready && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        b_if.valid = 1'b0;
        b_if.din   = ~words[i];
        n = 0;
        while (!b_if.done && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (!b_if.done) chk("b_done_timeout", 32'(b_if.done), 32'd1);
        else chk("b_loopback", 32'(rx), 32'(words[i]));
      end
    end
  endtask

  task automatic run_c();
    int unsigned acc1, acc2;
    int          gap, n, n_stb, n_done;
    rst_c      = 1'b1;
    c_if.valid = 1'b0;
    c_if.din   = '0;
    c_if.LR    = 1'b0;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    @(negedge clk);
    // Back-to-back with valid held high.
    c_if.din   = 8'h0F;
    c_if.valid = 1'b1;
    n = 0;
    while (!c_if.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc1 = cyc;
    @(negedge clk);
    c_if.din = 8'hF0;
    gap = 0;
    n   = 0;
    while (!c_if.ready && n < 100) begin
      if (!c_if.SO_en) gap++;
      @(negedge clk);
      n++;
    end
    if (!c_if.SO_en) gap++;
    acc2 = cyc;
    chk("c_b2b_spacing", acc2 - acc1, 32'd18);
    chk("c_b2b_gap", 32'(gap), 32'd2);
    @(negedge clk);
    c_if.valid = 1'b0;
    chk("c_second_frame_bit0", 32'({c_if.SO_en, c_if.SO}), 32'b11);
    n = 0;
    while (!c_if.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    // Mid-frame reset after bit 3 of 0xFF.
    c_if.din   = 8'hFF;
    c_if.valid = 1'b1;
    @(negedge clk);
    c_if.valid = 1'b0;
    n_stb = 0;
    n     = 0;
    while (n_stb < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (c_if.bit_stb) n_stb++;
    end
    chk("c_stb_count", 32'(n_stb), 32'd4);
    @(negedge clk);
    rst_c = 1'b1;
    @(negedge clk);
    chk("c_abort_outputs", 32'({c_if.SO, c_if.SO_en}), 32'd0);
    rst_c = 1'b0;
    @(negedge clk);
    chk("c_ready_after_abort", 32'(c_if.ready), 32'd1);
    n_done = 0;
    repeat (W * DIVC + 10) begin
      @(negedge clk);
      if (c_if.done) n_done++;
    end
    chk("c_no_done_after_abort", 32'(n_done), 32'd0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
